// File: rtl/podule_bus_bridge.sv
// -----------------------------------------------------------------------------
// podule_bus_bridge
//
// Upstream stage of the IDE podule. Turns a CPU Wishbone-style cycle that
// targets IOC bank 4 (the podule space) into a single-cycle select strobe on
// the podule interface. It inserts a speed-dependent number of wait cycles,
// captures the podule's (registered) read data, and acknowledges the CPU.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   wb_cyc     CPU bus cycle active
//   wb_stb     CPU strobe
//   wb_we      CPU write
//   wb_adr     CPU word address, byte address bits [25:2]
//   wb_dat_i   CPU write data; podule data travels on bits [31:16]
//   wb_dat_o   read data returned to the CPU
//   wb_ack     one-cycle transfer acknowledge
//   pod_sel    one-cycle podule select strobe
//   pod_we     podule write
//   pod_adr    podule word offset, byte address bits [13:2]
//   pod_dat_o  write data to the podule
//   pod_dat_i  read data from the podule (may lag pod_sel by one cycle)
// -----------------------------------------------------------------------------
module podule_bus_bridge #(
  parameter int SLOT      = 0,
  parameter int SLOW_WAIT = 7,
  parameter int MED_WAIT  = 5,
  parameter int FAST_WAIT = 3,
  parameter int SYNC_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [23:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        pod_sel,
  output logic        pod_we,
  output logic [11:0] pod_adr,
  output logic [15:0] pod_dat_o,
  input  logic [15:0] pod_dat_i
);

  localparam int         CNT_W   = 8;
  localparam logic [1:0] SLOT_ID = SLOT[1:0];

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    ACK,
    RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             present;
  logic             accept;
  logic             capture;

  // Address decode. wb_adr is a word address, so byte address bit k is
  // wb_adr[k-2]:
  //   A[25:22] -> wb_adr[23:20]  must be 4'b1100 (IOC space)
  //   A[18:16] -> wb_adr[16:14]  must be 3'd4    (bank 4, podules)
  //   A[20:19] -> wb_adr[18:17]  access speed
  //   A[15:14] -> wb_adr[13:12]  slot
  //   A[13:2]  -> wb_adr[11:0]   podule word offset
  logic        hit;
  logic [1:0]  speed;
  logic [1:0]  slot;
  logic [11:0] offset;

  assign hit    = wb_cyc & wb_stb & (wb_adr[23:20] == 4'b1100) &
                  (wb_adr[16:14] == 3'd4);
  assign speed  = wb_adr[18:17];
  assign slot   = wb_adr[13:12];
  assign offset = wb_adr[11:0];

  // Byte address bit 21 and the low half of the write data play no part in a
  // podule access.
  logic unused_bits;
  assign unused_bits = ^{wb_adr[19], wb_dat_i[15:0]};

  // Wait count for a speed code. Zero would leave WAIT with nothing to count
  // down from, so it is raised to one; very large values saturate at the
  // counter's range.
  function automatic logic [CNT_W-1:0] wait_for(input logic [1:0] spd);
    int w;
    case (spd)
      2'd0:    w = SLOW_WAIT;
      2'd1:    w = MED_WAIT;
      2'd2:    w = FAST_WAIT;
      default: w = SYNC_WAIT;
    endcase
    if (w < 1) w = 1;
    if (w > (1 << CNT_W) - 1) w = (1 << CNT_W) - 1;
    return w[CNT_W-1:0];
  endfunction

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          accept    = 1'b1;
          cnt_nxt   = wait_for(speed);
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // A count of 0 cannot be loaded; it is treated like 1 so the FSM can
        // never get stuck here.
        if (cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACK: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Holding stb after the ack must not start a second podule access.
        if (!wb_stb) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and the registered transfer fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      present   <= 1'b0;
      pod_we    <= 1'b0;
      pod_adr   <= '0;
      pod_dat_o <= '0;
      wb_dat_o  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Fields are frozen at accept; later bus changes are ignored until the
      // FSM is back in IDLE.
      if (accept) begin
        pod_we    <= wb_we;
        pod_adr   <= offset;
        pod_dat_o <= wb_dat_i[31:16];
        present   <= (slot == SLOT_ID);
      end
      // Read data is captured even if the CPU has dropped the cycle; only
      // the ack is suppressed for an aborted transfer. An empty slot reads
      // as all ones, like an undriven bus.
      if (capture && !pod_we) begin
        wb_dat_o <= present ? {16'h0000, pod_dat_i} : 32'hFFFF_FFFF;
      end
    end
  end

  // Strobe and ack are decoded from state so each lasts exactly one cycle.
  always_comb begin
    pod_sel = (state == STROBE) & present;
    wb_ack  = (state == ACK) & wb_cyc & wb_stb;
  end

endmodule

// File: tb/tb_podule_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_podule_bus_bridge
//
// Self-checking bench for podule_bus_bridge: a table of directed transfers
// with hand-written expectations, hand-written sequences for held strobe and
// reset during a wait, then randomized transfers whose expectations come from
// a transaction-level model of the bridge.
// -----------------------------------------------------------------------------
module tb_podule_bus_bridge;

  localparam int SLOT      = 0;
  localparam int SLOW_WAIT = 7;
  localparam int MED_WAIT  = 5;
  localparam int FAST_WAIT = 3;
  localparam int SYNC_WAIT = 1;

  logic        clk;
  logic        rst_n;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        pod_sel;
  logic        pod_we;
  logic [11:0] pod_adr;
  logic [15:0] pod_dat_o;
  logic [15:0] pod_dat_i;

  int          n_tests;
  int          n_fail;
  logic [31:0] cur_dat;   // expected wb_dat_o between transfers

  podule_bus_bridge #(
    .SLOT      (SLOT),
    .SLOW_WAIT (SLOW_WAIT),
    .MED_WAIT  (MED_WAIT),
    .FAST_WAIT (FAST_WAIT),
    .SYNC_WAIT (SYNC_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack    (wb_ack),
    .pod_sel   (pod_sel),
    .pod_we    (pod_we),
    .pod_adr   (pod_adr),
    .pod_dat_o (pod_dat_o),
    .pod_dat_i (pod_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [23:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [15:0] pdat;
    int          n;        // wait count; 0 = not a podule hit
    logic        sel;      // pod_sel expected at cycle 1
    logic [31:0] fin;      // wb_dat_o after the transfer
    int          abort_t;  // cycle at which cyc/stb drop; 0 = never
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Word address of a podule access built from its fields.
  function automatic logic [23:0] mk(input logic [1:0] spd, input logic [1:0] sl,
                                     input logic [11:0] off);
    return {4'hC, 1'b0, spd, 3'd4, sl, off};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input string nm, input int k);
    for (int i = 0; i < k; i++) begin
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      @(negedge clk);
      chk({nm, ".idle_ack"}, 32'(wb_ack), 32'd0);
      chk({nm, ".idle_sel"}, 32'(pod_sel), 32'd0);
      next_cycle();
    end
  endtask

  // One CPU transfer, accepted at cycle 0, checked cycle by cycle.
  task automatic run_txn(input vec_t v);
    int last;
    logic cyc_on;
    last = (v.n == 0) ? 10 : 2 + v.n;
    for (int t = 0; t <= last; t++) begin
      cyc_on    = (v.abort_t == 0) || (t < v.abort_t);
      wb_cyc    = cyc_on;
      wb_stb    = cyc_on;
      // After accept the bus fields are scrambled; the bridge must ignore them.
      if (v.n > 0 && t >= 1) begin
        wb_adr   = ~v.adr;
        wb_we    = ~v.we;
        wb_dat_i = ~v.wdat;
      end else begin
        wb_adr   = v.adr;
        wb_we    = v.we;
        wb_dat_i = v.wdat;
      end
      pod_dat_i = (t >= 2) ? v.pdat : 16'hDEAD;
      @(negedge clk);
      chk({v.nm, ".sel"}, 32'(pod_sel), 32'((t == 1) && v.sel));
      chk({v.nm, ".ack"}, 32'(wb_ack),
          32'((v.n > 0) && (t == 2 + v.n) && (v.abort_t == 0)));
      chk({v.nm, ".dat_o"}, wb_dat_o, (v.n > 0 && t >= 2 + v.n) ? v.fin : cur_dat);
      if (v.n > 0 && t >= 1) begin
        chk({v.nm, ".pod_we"}, 32'(pod_we), 32'(v.we));
        chk({v.nm, ".pod_adr"}, 32'(pod_adr), 32'(v.adr[11:0]));
        chk({v.nm, ".pod_dat_o"}, 32'(pod_dat_o), 32'(v.wdat[31:16]));
      end
      next_cycle();
    end
    cur_dat = v.fin;
    idle_cycles(v.nm, 2);
  endtask

  initial begin
    int          sels;
    int          acks;
    int          waits[4];
    vec_t        v;
    logic [25:0] ba;
    logic        hit;
    logic [1:0]  spd;
    logic [1:0]  sl;
    logic        pres;

    n_tests = 0;
    n_fail  = 0;
    cur_dat = 32'h0;
    waits   = '{SLOW_WAIT, MED_WAIT, FAST_WAIT, SYNC_WAIT};

    tbl[0] = '{"sync_rd",     24'hC70800,          1'b0, 32'h0,          16'h00A5, 1, 1'b1, 32'h0000_00A5, 0};
    tbl[1] = '{"slow_wr",     mk(2'd0, 2'd0, 12'h800), 1'b1, 32'h0003_0000, 16'h0,    7, 1'b1, 32'h0000_00A5, 0};
    tbl[2] = '{"absent_rd",   mk(2'd2, 2'd2, 12'h040), 1'b0, 32'h0,          16'h1111, 3, 1'b0, 32'hFFFF_FFFF, 0};
    tbl[3] = '{"med_rd",      mk(2'd1, 2'd0, 12'hFFF), 1'b0, 32'h0,          16'h1234, 5, 1'b1, 32'h0000_1234, 0};
    tbl[4] = '{"abort_rd",    mk(2'd1, 2'd0, 12'h002), 1'b0, 32'h0,          16'hBEEF, 5, 1'b1, 32'h0000_BEEF, 2};
    tbl[5] = '{"after_abort", mk(2'd3, 2'd0, 12'h010), 1'b1, 32'hABCD_0000, 16'h0,    1, 1'b1, 32'h0000_BEEF, 0};
    tbl[6] = '{"absent_wr",   mk(2'd2, 2'd3, 12'h007), 1'b1, 32'h5555_0000, 16'h0,    3, 1'b0, 32'h0000_BEEF, 0};
    tbl[7] = '{"no_hit",      24'h800000,          1'b0, 32'h0,          16'h9999, 0, 1'b0, 32'h0000_BEEF, 0};

    rst_n     = 1'b0;
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    wb_adr    = '0;
    wb_dat_i  = '0;
    pod_dat_i = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset.ack", 32'(wb_ack), 32'd0);
    chk("reset.sel", 32'(pod_sel), 32'd0);
    chk("reset.dat_o", wb_dat_o, 32'd0);
    chk("reset.pod_we", 32'(pod_we), 32'd0);
    chk("reset.pod_adr", 32'(pod_adr), 32'd0);
    chk("reset.pod_dat_o", 32'(pod_dat_o), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Strobe held high long after the ack: one select, one ack.
    sels = 0;
    acks = 0;
    for (int t = 0; t < 24; t++) begin
      wb_cyc    = 1'b1;
      wb_stb    = 1'b1;
      wb_we     = 1'b0;
      wb_adr    = mk(2'd3, 2'd0, 12'h123);
      wb_dat_i  = '0;
      pod_dat_i = 16'h5A5A;
      @(negedge clk);
      sels += int'(pod_sel);
      acks += int'(wb_ack);
      if (t == 3) chk("hold.ack_at_3", 32'(wb_ack), 32'd1);
      next_cycle();
    end
    chk("hold.sel_count", 32'(sels), 32'd1);
    chk("hold.ack_count", 32'(acks), 32'd1);
    chk("hold.dat_o", wb_dat_o, 32'h0000_5A5A);
    cur_dat = 32'h0000_5A5A;
    idle_cycles("hold", 1);
    v = '{"post_hold", mk(2'd3, 2'd0, 12'h321), 1'b0, 32'h0, 16'h0042, 1, 1'b1, 32'h0000_0042, 0};
    run_txn(v);

    // Reset for one cycle while a slow read is waiting.
    for (int t = 0; t < 10; t++) begin
      wb_cyc    = (t < 4);
      wb_stb    = (t < 4);
      wb_we     = 1'b0;
      wb_adr    = mk(2'd0, 2'd0, 12'hABC);
      wb_dat_i  = 32'h7777_0000;
      pod_dat_i = 16'h4242;
      rst_n     = (t != 4);
      @(negedge clk);
      chk("rstwait.ack", 32'(wb_ack), 32'd0);
      if (t == 1) chk("rstwait.sel", 32'(pod_sel), 32'd1);
      if (t == 5) begin
        chk("rstwait.sel_after", 32'(pod_sel), 32'd0);
        chk("rstwait.dat_o", wb_dat_o, 32'd0);
        chk("rstwait.pod_we", 32'(pod_we), 32'd0);
        chk("rstwait.pod_adr", 32'(pod_adr), 32'd0);
        chk("rstwait.pod_dat_o", 32'(pod_dat_o), 32'd0);
      end
      next_cycle();
    end
    rst_n   = 1'b1;
    cur_dat = 32'h0;
    v = '{"nonpod_2000000", 24'h800000, 1'b0, 32'h0, 16'h1234, 0, 1'b0, 32'h0, 0};
    run_txn(v);

    // Randomized transfers against a transaction-level model.
    for (int k = 0; k < 60; k++) begin
      v.nm   = "rand";
      v.we   = 1'($urandom);
      v.wdat = $urandom;
      v.pdat = 16'($urandom);
      if ($urandom_range(0, 4) == 0) v.adr = 24'($urandom);
      else v.adr = mk(2'($urandom), 2'($urandom), 12'($urandom));
      ba   = {v.adr, 2'b00};
      hit  = (ba[25:22] == 4'b1100) && (ba[18:16] == 3'd4);
      spd  = ba[20:19];
      sl   = ba[15:14];
      pres = hit && (int'(sl) == SLOT);
      v.n  = !hit ? 0 : ((waits[spd] < 1) ? 1 : waits[spd]);
      v.sel = pres;
      if (!hit || v.we) v.fin = cur_dat;
      else if (pres) v.fin = {16'h0000, v.pdat};
      else v.fin = 32'hFFFF_FFFF;
      v.abort_t = (hit && $urandom_range(0, 5) == 0) ? $urandom_range(1, 2 + v.n) : 0;
      run_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
